// File: rtl/beat_packer.sv
// Packs RATIO narrow beats into one wide word with per-lane keep bits.
// m_last flushes a partially filled word early; the output register is a one-deep skid.
module beat_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [WIDTH-1:0]         m_data,
  input  logic                     m_last,
  output logic                     s_valid,
  input  logic                     s_ready,
  output logic [RATIO*WIDTH-1:0]   s_data,
  output logic [RATIO-1:0]         s_keep,
  output logic                     s_last
);

  localparam int CW = $clog2(RATIO);

  logic                   run;
  logic [CW-1:0]          cnt;
  logic [RATIO*WIDTH-1:0] acc;
  logic [RATIO*WIDTH-1:0] merged;
  logic [RATIO-1:0]       keep_next;
  logic                   out_valid;
  logic [RATIO*WIDTH-1:0] out_data;
  logic [RATIO-1:0]       out_keep;
  logic                   out_last;
  logic                   accept;
  logic                   complete;

  // Ready depends only on registered state and s_ready, never on m_valid.
  assign m_ready  = run && (!out_valid || s_ready);
  assign accept   = m_valid && m_ready;
  assign complete = (cnt == CW'(RATIO - 1)) || m_last;

  always_comb begin
    merged = acc;
    merged[cnt*WIDTH +: WIDTH] = m_data;
    keep_next = '0;
    for (int i = 0; i < RATIO; i++) begin
      keep_next[i] = (CW'(i) <= cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept && complete) begin
        out_valid <= 1'b1;
        out_data  <= merged;
        out_keep  <= keep_next;
        out_last  <= m_last;
        cnt       <= '0;
        acc       <= '0;
      end else begin
        if (accept) begin
          acc <= merged;
          cnt <= cnt + 1'b1;
        end
        // Drain only when no new word replaces the current one at this edge.
        if (out_valid && s_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign s_valid = out_valid;
  assign s_data  = out_data;
  assign s_keep  = out_keep;
  assign s_last  = out_last;

endmodule

// File: tb/tb_beat_packer.sv
// Self-checking bench for beat_packer (WIDTH 8, RATIO 4) with an expected-word scoreboard.
module tb_beat_packer;

  typedef logic [36:0] word_t;  // {data[31:0], keep[3:0], last}

  logic        clk;
  logic        rst_n;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last;

  int    checks;
  int    failures;
  int    cyc;
  word_t sb[$];
  int    rx_cyc[$];
  word_t got;
  word_t exp_w;

  beat_packer #(.WIDTH(8), .RATIO(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_last  (s_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1ns after posedge, so a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && s_valid && s_ready) begin
      checks++;
      got = {s_data, s_keep, s_last};
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h expected=none", got);
      end else begin
        exp_w = sb.pop_front();
        if (got !== exp_w) begin
          failures++;
          $display("FAIL sb_word got data=%h keep=%b last=%b expected data=%h keep=%b last=%b",
                   s_data, s_keep, s_last, exp_w[36:5], exp_w[4:1], exp_w[0]);
        end
        rx_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    m_valid = 1'b1;
    m_data  = d;
    m_last  = l;
    checks++;
    if (m_ready !== 1'b1) begin
      failures++;
      $display("FAIL beat_ready data=%h got=%b expected=1", d, m_ready);
    end
    tick();
    m_valid = 1'b0;
    m_last  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({s_valid, s_data, s_keep, s_last, m_ready} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0", {s_valid, s_data, s_keep, s_last, m_ready});
    end
    tick();
    tick();
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (m_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready got=%b expected=0", m_ready);
    end
    tick();
    checks++;
    if (m_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_edge_ready got=%b expected=1", m_ready);
    end
  endtask

  task automatic test_full_word();
    s_ready = 1'b1;
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    sb.push_back({32'h44332211, 4'b1111, 1'b0});
    beat(8'h44, 1'b0);
    checks++;
    if ({s_valid, s_data, s_keep, s_last} !== {1'b1, 32'h44332211, 4'b1111, 1'b0}) begin
      failures++;
      $display("FAIL full_word got v=%b d=%h k=%b l=%b expected v=1 d=44332211 k=1111 l=0",
               s_valid, s_data, s_keep, s_last);
    end
    tick();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_word_drain got=%b expected=0", s_valid);
    end
  endtask

  task automatic test_early_flush();
    s_ready = 1'b1;
    beat(8'hAA, 1'b0);
    sb.push_back({32'h0000BBAA, 4'b0011, 1'b1});
    beat(8'hBB, 1'b1);
    checks++;
    if ({s_valid, s_data, s_keep, s_last} !== {1'b1, 32'h0000BBAA, 4'b0011, 1'b1}) begin
      failures++;
      $display("FAIL early_flush got v=%b d=%h k=%b l=%b expected v=1 d=0000bbaa k=0011 l=1",
               s_valid, s_data, s_keep, s_last);
    end
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    sb.push_back({32'h04030201, 4'b1111, 1'b1});
    beat(8'h04, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    s_ready = 1'b0;
    beat(8'h55, 1'b0);
    beat(8'h66, 1'b0);
    beat(8'h77, 1'b0);
    sb.push_back({32'h88776655, 4'b1111, 1'b0});
    beat(8'h88, 1'b0);
    m_valid = 1'b1;
    m_data  = 8'h99;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({m_ready, s_valid, s_data} !== {1'b0, 1'b1, 32'h88776655}) begin
        failures++;
        $display("FAIL bp_stall cycle=%0d got rdy=%b v=%b d=%h expected rdy=0 v=1 d=88776655",
                 i, m_ready, s_valid, s_data);
      end
      tick();
    end
    s_ready = 1'b1;
    #1;
    checks++;
    if (m_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready got=%b expected=1", m_ready);
    end
    tick();
    m_valid = 1'b0;
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got=%b expected=0", s_valid);
    end
    beat(8'hA1, 1'b0);
    beat(8'hA2, 1'b0);
    sb.push_back({32'hA3A2A199, 4'b1111, 1'b0});
    beat(8'hA3, 1'b0);
    tick();
  endtask

  task automatic test_streaming();
    s_ready = 1'b1;
    rx_cyc.delete();
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) begin
        sb.push_back({8'(8'hC0 + i), 8'(8'hC0 + i - 1), 8'(8'hC0 + i - 2), 8'(8'hC0 + i - 3),
                      4'b1111, 1'b0});
      end
      beat(8'(8'hC0 + i), 1'b0);
      m_valid = 1'b1;
    end
    m_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (rx_cyc.size() != 3) begin
      failures++;
      $display("FAIL stream_count got=%0d expected=3", rx_cyc.size());
    end else begin
      checks++;
      if ((rx_cyc[1] - rx_cyc[0] != 4) || (rx_cyc[2] - rx_cyc[1] != 4)) begin
        failures++;
        $display("FAIL stream_spacing got=%0d,%0d expected=4,4",
                 rx_cyc[1] - rx_cyc[0], rx_cyc[2] - rx_cyc[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    s_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back({24'h0, 8'(8'h71 + i), 4'b0001, 1'b1});
      beat(8'(8'h71 + i), 1'b1);
      checks++;
      if ({s_valid, s_data} !== {1'b1, 24'h0, 8'(8'h71 + i)}) begin
        failures++;
        $display("FAIL b2b_word idx=%0d got v=%b d=%h expected v=1 d=%h",
                 i, s_valid, s_data, 8'(8'h71 + i));
      end
    end
    tick();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got=%b expected=0", s_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    s_ready = 1'b1;
    beat(8'h31, 1'b0);
    beat(8'h32, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_valid, s_data, s_keep, s_last, m_ready} !== 39'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h expected=0", {s_valid, s_data, s_keep, s_last, m_ready});
    end
    tick();
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (m_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_release_ready got=%b expected=0", m_ready);
    end
    tick();
    beat(8'hE1, 1'b0);
    beat(8'hE2, 1'b0);
    beat(8'hE3, 1'b0);
    sb.push_back({32'hE4E3E2E1, 4'b1111, 1'b0});
    beat(8'hE4, 1'b0);
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    m_last   = 1'b0;
    s_ready  = 1'b1;
    test_reset();
    test_full_word();
    test_early_flush();
    test_backpressure();
    test_streaming();
    test_back_to_back();
    test_reset_mid_word();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
